mips_cpu_mult: RTL and testbench

- Multicycle shift-add multiplier in the MIPS CPU execute stage; the counterpart to the divider. Serves MULT (signed) and MULTU (unsigned).
- Takes two operands on a start pulse and produces a 2*WIDTH-bit product split into hi/lo, which the CPU writes into the HI/LO registers.
- Uses the same start/done handshake as the divider, so the CPU stall logic treats both units alike.

---
 rtl/mips_cpu_mult.sv | 101 ++++++++++
 tb/tb_mips_cpu_mult.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mult.sv
// Multicycle shift-add multiplier for MULT/MULTU in the execute stage.
// Shares the divider's start/done handshake; hi/lo change only on completion or reset.
module mips_cpu_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // ZERO is a one-cycle hold for the zero shortcut so done still lands after edge N+1.
    typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic               neg;
    logic [CW-1:0]      counter;

    logic               accept;
    logic               zero_op;
    logic               last;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_nxt;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic n);
        return n ? (~p + 1'b1) : p;
    endfunction

    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        zero_op  = (multiplicand == '0) || (multiplier == '0);
        last     = (counter == LAST);
        mag_a    = magnitude(multiplicand, is_signed);
        mag_b    = magnitude(multiplier, is_signed);
        // The extra sum bit keeps the carry out of upper + |A| for exact unsigned products.
        sum      = prod[0] ? ({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                           : {1'b0, prod[2*WIDTH-1:WIDTH]};
        prod_nxt = {sum, prod[WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = zero_op ? ZERO : RUN;
                else        state_nxt = IDLE;
            end
            RUN:     if (last) state_nxt = DONE;
            ZERO:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)              counter <= '0;
        else if (accept)        counter <= '0;
        else if (state == RUN)  counter <= counter + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mcand <= mag_a;
            prod  <= {{WIDTH{1'b0}}, mag_b};
            neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        end else if (state == RUN) begin
            prod  <= prod_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                      {hi, lo} <= '0;
        else if (state == RUN && last)  {hi, lo} <= apply_sign(prod_nxt, neg);
        else if (state == ZERO)         {hi, lo} <= '0;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mips_cpu_mult.sv
// Randomized self-checking bench for mips_cpu_mult against a plain-arithmetic product model.
module tb_mips_cpu_mult;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  prev = '0;

    mips_cpu_mult #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .is_signed(is_signed),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Drives a start at the current negedge, returns just after edge N with inputs scrambled.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        start        = 1'b1;
        is_signed    = s;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        start        = 1'b0;
        is_signed    = 1'($urandom);
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Waits for done; k counts negedges, k=j is just after edge N+j.
    task automatic wait_result(input string tag, input logic [63:0] exp, input bit zero, input bit poke);
        int lat = -1;
        int bad_busy = 0;
        int bad_hold = 0;
        bit seen = 0;
        for (int k = 0; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (busy !== (!zero && k < W)) bad_busy++;
            if (done === 1'b1) begin
                seen = 1;
                lat  = k;
            end else if ({hi, lo} !== prev) begin
                bad_hold++;
            end
            if (poke && k == 10) begin
                start        = 1'b1;
                is_signed    = 1'($urandom);
                multiplicand = $urandom | 1;
                multiplier   = $urandom | 1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_busy"}, 64'(bad_busy), 64'd0);
        check({tag, "_hold"}, 64'(bad_hold), 64'd0);
        check({tag, "_latency"}, 64'(lat), zero ? 64'd1 : 64'(W));
        check({tag, "_hilo"}, {hi, lo}, exp);
        prev = exp;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit s, input bit poke);
        start_op(a, b, s);
        wait_result(tag, model(a, b, s), (a == '0) || (b == '0), poke);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_idle_hilo"}, {hi, lo}, prev);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        is_signed    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("u_small", 32'd7, 32'd6, 0, 0);
        check("u_small_lit", {hi, lo}, 64'h0000_0000_0000_002A);
        idle_cycle("u_small");
        do_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("u_max_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        idle_cycle("u_max");
        do_op("s_mixed", 32'hFFFF_FFFD, 32'd5, 1, 0);
        check("s_mixed_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("s_minmin", 32'h8000_0000, 32'h8000_0000, 1, 0);
        check("s_minmin_lit", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op("s_minm1", 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        check("s_minm1_lit", {hi, lo}, 64'h0000_0000_8000_0000);

        do_op("zero", 32'd0, 32'h1234_5678, 1, 0);
        for (int i = 0; i < 5; i++) idle_cycle("zero_hold");

        do_op("poke", 32'h0001_2345, 32'hFEDC_BA98, 0, 1);
        idle_cycle("poke");

        // Abandon an operation partway; no done may follow.
        begin
            int stray = 0;
            start_op(32'h0BAD_CAFE, 32'h1357_9BDF, 1);
            for (int k = 0; k < 20; k++) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("midrst_busy", 64'(busy), 64'd0);
            check("midrst_done", 64'(done), 64'd0);
            check("midrst_hilo", {hi, lo}, 64'd0);
            reset = 1'b0;
            prev  = '0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) stray++;
            end
            check("midrst_no_done", 64'(stray), 64'd0);
        end

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a = rand_operand();
            logic [W-1:0] b = rand_operand();
            bit s = 1'($urandom);
            bit zero = (a == '0) || (b == '0);
            do_op("rand", a, b, s, !zero && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) idle_cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
